edge_waveform_gen: RTL

EDGE_WAVEFORM_GEN -- requirements
Module: edge_waveform_gen

---
 rtl/edge_waveform_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/edge_waveform_gen.sv
// Interval-driven waveform generator: replays queued hold times as dout toggles.
// Each FIFO entry produces exactly one dout edge after its programmed number of cycles.
module edge_waveform_gen #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CW-1:0]            wr_interval,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     init_level,
    output logic                     dout,
    output logic                     edge_strobe,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]    FullCount = (AW+1)'(DEPTH);
    localparam logic [CW-1:0]  CntOne    = CW'(1);
    localparam logic [0:0]     StIdle    = 1'b0;
    localparam logic [0:0]     StCount   = 1'b1;

    logic [CW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          full, empty, push, pop;
    logic [CW-1:0] head, head_eff;

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    // A programmed hold of zero still needs one cycle to produce its edge.
    assign head_eff = (head == '0) ? CntOne : head;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !empty) begin
                    state_d = StCount;
                    dout_d  = init_level;
                    cnt_d   = head_eff;
                    pop     = 1'b1;
                end
            end
            StCount: begin
                if (cnt_q > CntOne) begin
                    cnt_d = cnt_q - CntOne;
                end else begin
                    dout_d   = ~dout_q;
                    strobe_d = 1'b1;
                    // Reload decision uses registered occupancy, so a same-cycle push is not bypassed.
                    if (!empty) begin
                        cnt_d = head_eff;
                        pop   = 1'b1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A full FIFO still takes a push when the same cycle frees a slot.
    assign push  = wr_en && (!full || pop);
    assign ovf_d = ovf_q | (wr_en && full && !pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= wr_interval;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_ready    = (count_q != FullCount);
    assign dout        = dout_q;
    assign edge_strobe = strobe_q;
    assign done        = done_q;
    assign busy        = (state_q == StCount);
    assign fifo_count  = count_q;
    assign ovf         = ovf_q;

endmodule
